onehot_scan_dec: RTL and testbench

Parametrised, registered one-hot decoder. It generalises the fixed 3-to-8 combinational decoder to any select width. It adds a valid/ready load port, an enable, and an auto-scan mode that steps the active output through every position at a programmable rate. It sits between control logic and multiplexed outputs such as display digit/anode selects, row strobes and bank enables.

---
 rtl/onehot_scan_dec_pkg.sv | 29 ++
 rtl/onehot_scan_dec_if.sv | 23 ++
 rtl/onehot_scan_dec_prescaler.sv | 27 ++
 rtl/onehot_scan_dec.sv | 112 +++++++++++
 tb/tb_onehot_scan_dec.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/onehot_scan_dec_pkg.sv
// Shared types and helpers for the registered one-hot scan decoder.
package onehot_dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam int SEL_W_MAX = 6;
  localparam int RES_W_MAX = 2 ** SEL_W_MAX;
  localparam int SEL_W_DEF = 3;
  localparam int N_DEF     = 2 ** SEL_W_DEF;

  function automatic int res_w(input int sel_w);
    return 2 ** sel_w;
  endfunction

  function automatic int cnt_w(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

  // Widest vector; callers size-cast the result down to their own N.
  function automatic logic [RES_W_MAX-1:0] onehot(input logic [SEL_W_MAX-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

endpackage

// File: rtl/onehot_scan_dec_if.sv
// Load/enable/output bundle between control logic and the one-hot decoder.
interface onehot_scan_dec_if #(
  parameter int SEL_W = 3
);
  logic                  en;
  logic                  mode;
  logic                  sel_valid;
  logic [SEL_W-1:0]      sel;
  logic                  sel_ready;
  logic [2**SEL_W-1:0]   res;
  logic [SEL_W-1:0]      idx;
  logic                  step;

  modport master (
    output en, mode, sel_valid, sel,
    input  sel_ready, res, idx, step
  );

  modport slave (
    input  en, mode, sel_valid, sel,
    output sel_ready, res, idx, step
  );
endinterface

// File: rtl/onehot_scan_dec_prescaler.sv
// Scan-rate counter: wraps every PRESCALE cycles while run is high; clr wins over run.
module scan_prescaler
  import onehot_dec_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         run,
  output logic [cnt_w(PRESCALE)-1:0]   cnt,
  output logic                         tc,
  output logic                         pre_tc
);
  localparam int CNT_W = cnt_w(PRESCALE);

  assign tc     = (cnt == CNT_W'(PRESCALE - 1));
  assign pre_tc = (cnt == CNT_W'(PRESCALE - 2));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/onehot_scan_dec.sv
// Registered one-hot decoder with direct load and auto-scan modes.
// Optional DEC_BLANK_EN inserts one all-zero cycle before each scan step.
module onehot_scan_dec
  import onehot_dec_pkg::*;
#(
  parameter int SEL_W    = 3,
  parameter int PRESCALE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  onehot_scan_dec_if.slave   bus
);
  localparam int N     = res_w(SEL_W);
  localparam int CNT_W = cnt_w(PRESCALE);

  state_t             state;
  logic [N-1:0]       res;
  logic [SEL_W-1:0]   idx;
  logic [SEL_W-1:0]   idx_nxt;
  logic               step;
  logic [N-1:0]       oh_cur;
  logic [N-1:0]       oh_nxt;
  logic [N-1:0]       oh_sel;
  logic               load;
  logic               run;
  logic               tc;
  logic               pre_tc;
  logic               blank;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_unused;

  assign idx_nxt = idx + 1'b1;
  assign oh_cur  = N'(onehot(SEL_W_MAX'(idx)));
  assign oh_nxt  = N'(onehot(SEL_W_MAX'(idx_nxt)));
  assign oh_sel  = N'(onehot(SEL_W_MAX'(bus.sel)));

  assign bus.sel_ready = (state == DIRECT) & bus.en & ~bus.mode;
  assign load          = bus.sel_valid & bus.sel_ready;

  // Counter only runs while staying in SCAN; every other path leaves it cleared.
  assign run = (state == SCAN) & bus.en & bus.mode;

  scan_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (~run),
    .run    (run),
    .cnt    (cnt),
    .tc     (tc),
    .pre_tc (pre_tc)
  );

  assign cnt_unused = ^cnt;

`ifdef DEC_BLANK_EN
  assign blank = pre_tc;
`else
  logic pre_tc_unused;
  assign blank         = 1'b0;
  assign pre_tc_unused = pre_tc;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      res   <= '0;
      idx   <= '0;
      step  <= 1'b0;
    end else if (!bus.en) begin
      state <= IDLE;
      res   <= '0;
      step  <= 1'b0;
    end else begin
      step <= 1'b0;
      case (state)
        IDLE: begin
          state <= bus.mode ? SCAN : DIRECT;
          res   <= oh_cur;
        end
        DIRECT: begin
          if (bus.mode) begin
            state <= SCAN;
          end else if (load) begin
            idx <= bus.sel;
            res <= oh_sel;
          end
        end
        SCAN: begin
          // Restore from idx on exit so a blanked cycle never leaks into DIRECT.
          if (!bus.mode) begin
            state <= DIRECT;
            res   <= oh_cur;
          end else if (tc) begin
            idx  <= idx_nxt;
            res  <= oh_nxt;
            step <= 1'b1;
          end else if (blank) begin
            res <= '0;
          end
        end
        default: begin
          state <= IDLE;
          res   <= '0;
        end
      endcase
    end
  end

  assign bus.res  = res;
  assign bus.idx  = idx;
  assign bus.step = step;
endmodule

// File: tb/tb_onehot_scan_dec.sv
// Directed bench for onehot_scan_dec at SEL_W=3, PRESCALE=4.
module tb_onehot_scan_dec;
`ifdef DEC_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  onehot_scan_dec_if #(.SEL_W(3)) bus ();

  onehot_scan_dec #(.SEL_W(3), .PRESCALE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.en = 1'b0; bus.mode = 1'b0; bus.sel_valid = 1'b0; bus.sel = 3'd0;
    cyc(); cyc();
    total++; if (bus.res !== 8'h00) begin bad++; $display("FAIL reset_res got=%h want=00", bus.res); end
    total++; if (bus.idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", bus.idx); end
    total++; if (bus.step !== 1'b0) begin bad++; $display("FAIL reset_step got=%b want=0", bus.step); end
    total++; if (bus.sel_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.sel_ready); end
  endtask

  task automatic test_direct_load();
    rst_n = 1'b1; bus.en = 1'b1; bus.mode = 1'b0;
    cyc();
    total++; if (bus.res !== 8'h01) begin bad++; $display("FAIL enable_res got=%h want=01", bus.res); end
    bus.sel = 3'd5; bus.sel_valid = 1'b1;
    #1;
    total++; if (bus.sel_ready !== 1'b1) begin bad++; $display("FAIL load_ready got=%b want=1", bus.sel_ready); end
    cyc();
    bus.sel_valid = 1'b0;
    total++; if (bus.res !== 8'b0010_0000) begin bad++; $display("FAIL load_res got=%h want=20", bus.res); end
    total++; if (bus.idx !== 3'd5) begin bad++; $display("FAIL load_idx got=%0d want=5", bus.idx); end
    cyc(); cyc();
    total++; if (bus.res !== 8'h20) begin bad++; $display("FAIL hold_res got=%h want=20", bus.res); end
  endtask

  task automatic test_scan_wrap();
    logic [7:0] exp_res;
    int         nsteps;
    nsteps = 0;
    bus.sel = 3'd6; bus.sel_valid = 1'b1;
    cyc();
    bus.sel_valid = 1'b0;
    total++; if (bus.res !== 8'h40) begin bad++; $display("FAIL pre_scan_res got=%h want=40", bus.res); end
    // sel_valid stays high through the scan and must be ignored.
    bus.mode = 1'b1; bus.sel_valid = 1'b1; bus.sel = 3'd2;
    cyc();
    total++; if (bus.sel_ready !== 1'b0) begin bad++; $display("FAIL scan_ready got=%b want=0", bus.sel_ready); end
    for (int e = 0; e <= 32; e++) begin
      int pos;
      int phase;
      if (e > 0) cyc();
      pos     = (6 + e / 4) % 8;
      phase   = e % 4;
      exp_res = 8'(1) << pos;
      if (BLANK && phase == 3) exp_res = 8'h00;
      if (bus.step === 1'b1) nsteps++;
      total++; if (bus.res !== exp_res) begin bad++; $display("FAIL scan_res e=%0d got=%h want=%h", e, bus.res, exp_res); end
      total++; if (bus.idx !== 3'(pos)) begin bad++; $display("FAIL scan_idx e=%0d got=%0d want=%0d", e, bus.idx, pos); end
      total++; if (bus.step !== (e > 0 && phase == 0)) begin bad++; $display("FAIL scan_step e=%0d got=%b want=%b", e, bus.step, (e > 0 && phase == 0)); end
      total++; if ($countones(bus.res) > 1) begin bad++; $display("FAIL scan_multihot e=%0d got=%h want=onehot_or_zero", e, bus.res); end
    end
    bus.sel_valid = 1'b0;
    total++; if (nsteps != 8) begin bad++; $display("FAIL scan_step_count got=%0d want=8", nsteps); end
  endtask

  task automatic test_mode_switch();
    logic [7:0] exp_res;
    bus.mode = 1'b0;
    cyc();
    bus.sel = 3'd3; bus.sel_valid = 1'b1;
    cyc();
    bus.sel_valid = 1'b0;
    bus.mode = 1'b1;
    cyc(); cyc();
    bus.mode = 1'b0;
    cyc();
    total++; if (bus.res !== 8'h08) begin bad++; $display("FAIL mode0_res got=%h want=08", bus.res); end
    total++; if (bus.idx !== 3'd3) begin bad++; $display("FAIL mode0_idx got=%0d want=3", bus.idx); end
    total++; if (bus.sel_ready !== 1'b1) begin bad++; $display("FAIL mode0_ready got=%b want=1", bus.sel_ready); end
    bus.mode = 1'b1;
    cyc();
    for (int e = 1; e <= 4; e++) begin
      cyc();
      exp_res = (e == 4) ? 8'h10 : ((BLANK && e == 3) ? 8'h00 : 8'h08);
      total++; if (bus.res !== exp_res) begin bad++; $display("FAIL mode1_res e=%0d got=%h want=%h", e, bus.res, exp_res); end
      total++; if (bus.step !== (e == 4)) begin bad++; $display("FAIL mode1_step e=%0d got=%b want=%b", e, bus.step, (e == 4)); end
    end
    total++; if (bus.idx !== 3'd4) begin bad++; $display("FAIL mode1_idx got=%0d want=4", bus.idx); end
  endtask

  task automatic test_disable_collision();
    bus.mode = 1'b0;
    cyc();
    bus.en = 1'b0; bus.sel_valid = 1'b1; bus.sel = 3'd2;
    #1;
    total++; if (bus.sel_ready !== 1'b0) begin bad++; $display("FAIL dis_ready got=%b want=0", bus.sel_ready); end
    cyc();
    total++; if (bus.res !== 8'h00) begin bad++; $display("FAIL dis_res got=%h want=00", bus.res); end
    total++; if (bus.idx !== 3'd4) begin bad++; $display("FAIL dis_idx got=%0d want=4", bus.idx); end
    total++; if (bus.step !== 1'b0) begin bad++; $display("FAIL dis_step got=%b want=0", bus.step); end
    bus.sel_valid = 1'b0; bus.en = 1'b1;
    cyc();
    total++; if (bus.res !== 8'h10) begin bad++; $display("FAIL reen_res got=%h want=10", bus.res); end
  endtask

  task automatic test_reset_mid_scan();
    bus.mode = 1'b1;
    cyc();
    repeat (4) cyc();
    total++; if (bus.res !== 8'h20 || bus.step !== 1'b1) begin bad++; $display("FAIL midscan_res got=%h/%b want=20/1", bus.res, bus.step); end
    rst_n = 1'b0;
    cyc();
    total++; if (bus.res !== 8'h00) begin bad++; $display("FAIL rst_res got=%h want=00", bus.res); end
    total++; if (bus.idx !== 3'd0) begin bad++; $display("FAIL rst_idx got=%0d want=0", bus.idx); end
    total++; if (bus.step !== 1'b0) begin bad++; $display("FAIL rst_step got=%b want=0", bus.step); end
    cyc();
    rst_n = 1'b1; bus.en = 1'b0; bus.mode = 1'b0;
    cyc();
    total++; if (bus.res !== 8'h00) begin bad++; $display("FAIL post_rst_res got=%h want=00", bus.res); end
    bus.en = 1'b1;
    cyc();
    total++; if (bus.res !== 8'h01) begin bad++; $display("FAIL post_rst_en_res got=%h want=01", bus.res); end
    total++; if (bus.sel_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", bus.sel_ready); end
  endtask

  initial begin
    test_reset();
    test_direct_load();
    test_scan_wrap();
    test_mode_switch();
    test_disable_collision();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
